// File: rtl/uart_rx.sv
// uart_rx - 8N1 UART receiver with 16x oversampling.
//
// The serial line is synchronised, and a start is taken only on a falling
// edge. The start bit is re-checked at OS_MID ticks. Data bits and the stop
// bit are sampled at oversample count 15, which is mid-bit once the counter
// has been aligned in START. Completed bytes land in a valid/ready holding
// register. If a new byte arrives while the held byte has not been accepted,
// the new byte overwrites it and overrun pulses.
//
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit between
// the data and the stop bit, together with the par_err pulse output.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   rxd       asynchronous serial input, idles high
//   rx_ready  consumer accepts rx_data while rx_valid is high
//   rx_data   received byte (LSB first on the line)
//   rx_valid  rx_data holds an unconsumed byte
//   frame_err one-cycle pulse: stop bit sampled low
//   overrun   one-cycle pulse: an unconsumed byte was overwritten
//   busy      receiver is not idle
//   par_err   (UART_RX_PARITY_EN only) one-cycle pulse: parity check failed
module uart_rx #(
  parameter logic [15:0] CLK_DIV = 16'd27,
  parameter logic [3:0]  OS_MID  = 4'd7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
`ifdef UART_RX_PARITY_EN
  ,output logic      par_err
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t      state_q;
  logic        sync1_q, rxd_s_q, rxd_prev_q;
  logic [15:0] div_cnt_q;
  logic [3:0]  os_cnt_q;
  logic [3:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic [7:0]  rx_data_q;
  logic        rx_valid_q, frame_err_q, overrun_q;
  logic        fall, tick;
`ifdef UART_RX_PARITY_EN
  logic        par_bit_q, par_err_q;
`endif

  // Two-flop synchroniser plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      rxd_s_q    <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      sync1_q    <= rxd;
      rxd_s_q    <= sync1_q;
      rxd_prev_q <= rxd_s_q;
    end
  end

  assign fall = rxd_prev_q & ~rxd_s_q;
  assign tick = (div_cnt_q == CLK_DIV - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      div_cnt_q   <= 16'd0;
      os_cnt_q    <= 4'd0;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q   <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
      // A consumer handshake clears valid. A byte completing in this same
      // cycle overrides the clear further down.
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;

      if (state_q == IDLE || tick) div_cnt_q <= 16'd0;
      else                         div_cnt_q <= div_cnt_q + 16'd1;

      case (state_q)
        IDLE: begin
          if (fall) begin
            state_q  <= START;
            os_cnt_q <= 4'd0;
          end
        end
        START: begin
          if (tick) begin
            if (os_cnt_q == OS_MID) begin
              os_cnt_q  <= 4'd0;
              bit_cnt_q <= 4'd0;
              state_q   <= rxd_s_q ? IDLE : DATA;
            end else begin
              os_cnt_q <= os_cnt_q + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            // Wrapping 15 -> 0 realigns the counter for the next bit.
            os_cnt_q <= os_cnt_q + 4'd1;
            if (os_cnt_q == 4'd15) begin
              shift_q   <= {rxd_s_q, shift_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
`ifdef UART_RX_PARITY_EN
                state_q <= PARITY;
`else
                state_q <= STOP;
`endif
              end
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            os_cnt_q <= os_cnt_q + 4'd1;
            if (os_cnt_q == 4'd15) begin
              par_bit_q <= rxd_s_q;
              state_q   <= STOP;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            os_cnt_q <= os_cnt_q + 4'd1;
            if (os_cnt_q == 4'd15) begin
              state_q <= IDLE;
              if (!rxd_s_q) begin
                frame_err_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
              end else if (^{shift_q, par_bit_q}) begin
                par_err_q <= 1'b1;
`endif
              end else begin
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
                if (rx_valid_q && !rx_ready) overrun_q <= 1'b1;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign par_err   = par_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int BIT = 64;  // CLK_DIV=4 -> 16 ticks * 4 clk per bit

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
  logic       par_err;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  // Event counters, written only by the monitor below.
  int valid_cyc = 0, valid_rise = 0, fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, busy_cyc = 0;
  logic [7:0] cap = 8'h00;
  logic vprev = 1'b0;

  uart_rx #(.CLK_DIV(16'd4), .OS_MID(4'd7)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
`ifdef UART_RX_PARITY_EN
    ,.par_err(par_err)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) valid_cyc++;
    if (rx_valid && !vprev) begin
      valid_rise++;
      cap = rx_data;
    end
    vprev = rx_valid;
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (busy) busy_cyc++;
`ifdef UART_RX_PARITY_EN
    if (par_err) pe_cnt++;
`endif
  end

  // Drives one frame. The line is left at the stop-bit level on return.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
    @(negedge clk);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (BIT) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rxd = par_v;
    repeat (BIT) @(negedge clk);
`endif
    rxd = stop_v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame(d, 1'b1, ^d);
    rxd = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    total_cnt++; if (rx_data !== 8'h00) $display("FAIL reset_data got %h want 00", rx_data); else pass_cnt++;
    total_cnt++; if (rx_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", rx_valid); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_fe got %b want 0", frame_err); else pass_cnt++;
    total_cnt++; if (overrun !== 1'b0) $display("FAIL reset_ov got %b want 0", overrun); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    $display("reset: data=%h valid=%b busy=%b", rx_data, rx_valid, busy);
  endtask

  task automatic test_basic();
    int r0, v0, f0, o0;
    r0 = valid_rise; v0 = valid_cyc; f0 = fe_cnt; o0 = ov_cnt;
    send_byte(8'h55);
    total_cnt++; if (valid_rise - r0 !== 1) $display("FAIL basic_rise got %0d want 1", valid_rise - r0); else pass_cnt++;
    total_cnt++; if (valid_cyc - v0 !== 1) $display("FAIL basic_valid_cycles got %0d want 1", valid_cyc - v0); else pass_cnt++;
    total_cnt++; if (cap !== 8'h55) $display("FAIL basic_data got %h want 55", cap); else pass_cnt++;
    total_cnt++; if (fe_cnt - f0 !== 0) $display("FAIL basic_fe got %0d want 0", fe_cnt - f0); else pass_cnt++;
    total_cnt++; if (ov_cnt - o0 !== 0) $display("FAIL basic_ov got %0d want 0", ov_cnt - o0); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL basic_busy got %b want 0", busy); else pass_cnt++;
    $display("basic: sent 55 got %h", cap);
  endtask

  task automatic test_glitch();
    int r0, f0, b0;
    r0 = valid_rise; f0 = fe_cnt; b0 = busy_cyc;
    @(negedge clk);
    rxd = 1'b0;
    repeat (24) @(negedge clk);
    rxd = 1'b1;
    repeat (100) @(negedge clk);
    total_cnt++; if (busy_cyc - b0 < 1) $display("FAIL glitch_busy_seen got %0d want >=1", busy_cyc - b0); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL glitch_busy_end got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (valid_rise - r0 !== 0) $display("FAIL glitch_valid got %0d want 0", valid_rise - r0); else pass_cnt++;
    total_cnt++; if (fe_cnt - f0 !== 0) $display("FAIL glitch_fe got %0d want 0", fe_cnt - f0); else pass_cnt++;
    send_byte(8'hA3);
    total_cnt++; if (cap !== 8'hA3 || valid_rise - r0 !== 1) $display("FAIL glitch_next got %h/%0d want a3/1", cap, valid_rise - r0); else pass_cnt++;
    $display("glitch: busy_cycles=%0d next byte %h", busy_cyc - b0, cap);
  endtask

  task automatic test_frame_err();
    int r0, f0, b0;
    r0 = valid_rise; f0 = fe_cnt;
    send_frame(8'hA3, 1'b0, ^8'hA3);
    b0 = busy_cyc;
    repeat (128) @(negedge clk);
    total_cnt++; if (busy_cyc - b0 !== 0) $display("FAIL break_busy got %0d want 0", busy_cyc - b0); else pass_cnt++;
    rxd = 1'b1;
    repeat (64) @(negedge clk);
    total_cnt++; if (fe_cnt - f0 !== 1) $display("FAIL frame_err_count got %0d want 1", fe_cnt - f0); else pass_cnt++;
    total_cnt++; if (valid_rise - r0 !== 0) $display("FAIL frame_err_valid got %0d want 0", valid_rise - r0); else pass_cnt++;
    send_byte(8'h3C);
    total_cnt++; if (rx_data !== 8'h3C || valid_rise - r0 !== 1) $display("FAIL frame_err_next got %h/%0d want 3c/1", rx_data, valid_rise - r0); else pass_cnt++;
    $display("frame_err: pulses=%0d next byte %h", fe_cnt - f0, rx_data);
  endtask

  task automatic test_back_to_back();
    int o0, f0;
    o0 = ov_cnt; f0 = fe_cnt;
    rx_ready = 1'b0;
    send_byte(8'h11);
    total_cnt++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) $display("FAIL b2b_first got %b/%h want 1/11", rx_valid, rx_data); else pass_cnt++;
    total_cnt++; if (ov_cnt - o0 !== 0) $display("FAIL b2b_no_ov got %0d want 0", ov_cnt - o0); else pass_cnt++;
    send_byte(8'h22);
    total_cnt++; if (ov_cnt - o0 !== 1) $display("FAIL b2b_ov got %0d want 1", ov_cnt - o0); else pass_cnt++;
    total_cnt++; if (rx_valid !== 1'b1 || rx_data !== 8'h22) $display("FAIL b2b_second got %b/%h want 1/22", rx_valid, rx_data); else pass_cnt++;
    total_cnt++; if (fe_cnt - f0 !== 0) $display("FAIL b2b_fe got %0d want 0", fe_cnt - f0); else pass_cnt++;
    rx_ready = 1'b1;
    @(negedge clk);
    total_cnt++; if (rx_valid !== 1'b0 || rx_data !== 8'h22) $display("FAIL b2b_consume got %b/%h want 0/22", rx_valid, rx_data); else pass_cnt++;
    $display("back_to_back: overruns=%0d data=%h", ov_cnt - o0, rx_data);
  endtask

  task automatic test_mid_reset();
    logic [7:0] d;
    int r0;
    d = 8'hF0;
    @(negedge clk);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = d[i];
      repeat (BIT) @(negedge clk);
    end
    total_cnt++; if (busy !== 1'b1) $display("FAIL midrst_busy_before got %b want 1", busy); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++; if (rx_data !== 8'h00 || rx_valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0)
      $display("FAIL midrst_outputs got %h/%b/%b/%b/%b want 00/0/0/0/0", rx_data, rx_valid, frame_err, overrun, busy);
    else pass_cnt++;
    rxd = 1'b1;
    repeat (100) @(negedge clk);
    r0 = valid_rise;
    send_byte(8'h0F);
    total_cnt++; if (cap !== 8'h0F || valid_rise - r0 !== 1) $display("FAIL midrst_next got %h/%0d want 0f/1", cap, valid_rise - r0); else pass_cnt++;
    $display("mid_reset: next byte %h", cap);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int r0, p0, f0;
    r0 = valid_rise; p0 = pe_cnt; f0 = fe_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    rxd = 1'b1;
    repeat (16) @(negedge clk);
    total_cnt++; if (cap !== 8'h07 || valid_rise - r0 !== 1) $display("FAIL par_good got %h/%0d want 07/1", cap, valid_rise - r0); else pass_cnt++;
    total_cnt++; if (pe_cnt - p0 !== 0) $display("FAIL par_good_pe got %0d want 0", pe_cnt - p0); else pass_cnt++;
    send_frame(8'h07, 1'b1, 1'b0);
    rxd = 1'b1;
    repeat (16) @(negedge clk);
    total_cnt++; if (pe_cnt - p0 !== 1) $display("FAIL par_bad_pe got %0d want 1", pe_cnt - p0); else pass_cnt++;
    total_cnt++; if (valid_rise - r0 !== 1) $display("FAIL par_bad_valid got %0d want 1", valid_rise - r0); else pass_cnt++;
    total_cnt++; if (fe_cnt - f0 !== 0) $display("FAIL par_bad_fe got %0d want 0", fe_cnt - f0); else pass_cnt++;
    $display("parity: par_err pulses=%0d", pe_cnt - p0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_mid_reset();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
